// File: rtl/des_sbox_layer.sv
// Iterative DES S-box substitution layer: one 48-bit word in, 32-bit S1..S8 word out,
// LANES S-box lookups per clock with valid/ready handshakes on both sides.
module des_sbox_layer #(
  parameter int unsigned LANES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:48] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:32] out_data
);

  localparam int unsigned STEPS  = 8 / LANES;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_layer: LANES must be 1, 2, 4 or 8");
  end

  // Each table holds 64 nibbles, entry (row*16 + col) first, i.e. in the MSB nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [STEP_W-1:0] step_q;
  logic [47:0]       in_q;
  logic [31:0]       out_q;
  logic              out_valid_q;
  logic [31:0]       busy_word;
  logic              last_step;

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] chunk);
    logic [5:0] idx;
    idx = {chunk[5], chunk[0], chunk[4:1]};
    // ~idx == 63 - idx, which locates the entry counted from the MSB end.
    return SBOX[box][{~idx, 2'b00} +: 4];
  endfunction

  // Output register with this step's LANES nibbles replaced by fresh lookups.
  always_comb begin
    logic [2:0] box;
    logic [5:0] chunk;
    busy_word = out_q;
    box       = '0;
    chunk     = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      box   = 3'(int'(step_q) * int'(LANES) + int'(l));
      chunk = in_q[6'(47 - 6 * int'(box)) -: 6];
      busy_word[5'(31 - 4 * int'(box)) -: 4] = sbox_lookup(box, chunk);
    end
  end

  assign last_step = (step_q == STEP_W'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      step_q      <= '0;
      in_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            in_q    <= in_data;
            step_q  <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          out_q <= busy_word;
          if (last_step) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              in_q    <= in_data;
              step_q  <= '0;
              state_q <= StBusy;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // out_ready -> in_ready is the only combinational path, and only in DONE.
  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

endmodule

// File: tb/tb_des_sbox_layer.sv
// Bench for des_sbox_layer: four instances (LANES = 1, 2, 4, 8) checked against
// an independent decimal-table DES S-box model through a per-test scoreboard queue.
module tb_des_sbox_layer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [47:0] in_data   [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [31:0] out_data  [4];

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_layer #(
      .LANES(1 << g)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g])
    );
  end

  // Standard DES S-boxes, row-major (row*16 + col).
  int sbox_tab [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [31:0] model(input logic [47:0] d);
    logic [31:0] r;
    logic [5:0]  c;
    int          row;
    int          col;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      c   = d[47 - 6 * b -: 6];
      row = int'({c[5], c[0]});
      col = int'(c[4:1]);
      r[31 - 4 * b -: 4] = 4'(sbox_tab[b][row * 16 + col]);
    end
    return r;
  endfunction

  // One clock of handshake stimulus; entered and left just after a falling edge.
  task automatic drive_cycle(input int i, input logic v, input logic [47:0] d, input logic r,
                             output logic acc, output logic got, output logic [31:0] dout);
    in_valid[i]  = v;
    in_data[i]   = d;
    out_ready[i] = r;
    #1;
    acc  = in_valid[i] && in_ready[i];
    got  = out_valid[i] && out_ready[i];
    dout = out_data[i];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1) begin
        errors++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, in_ready[i]);
      end
      checks++;
      if (out_valid[i] !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, out_valid[i]);
      end
      checks++;
      if (out_data[i] !== 32'h0) begin
        errors++; $display("FAIL reset_out_data[%0d]: got %h want 0", i, out_data[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_known_word(input string name, input logic [47:0] d, input logic [31:0] exp);
    int n;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid[i] = 1'b1; in_data[i] = d; out_ready[i] = 1'b0;
      #1;
      checks++;
      if (in_ready[i] !== 1'b1) begin
        errors++; $display("FAIL %s_ready[%0d]: got %b want 1", name, i, in_ready[i]);
      end
      @(posedge clk); #1;
      in_valid[i] = 1'b0; in_data[i] = ~d;
      n = 0;
      while (out_valid[i] !== 1'b1 && n < 20) begin
        @(posedge clk); #1; n++;
      end
      checks++;
      if (n != (8 >> i)) begin
        errors++; $display("FAIL %s_latency[%0d]: got %0d want %0d", name, i, n, 8 >> i);
      end
      checks++;
      if (out_data[i] !== exp) begin
        errors++; $display("FAIL %s_data[%0d]: got %h want %h", name, i, out_data[i], exp);
      end
      @(negedge clk);
      out_ready[i] = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid[i] !== 1'b0) begin
        errors++; $display("FAIL %s_drain[%0d]: got %b want 0", name, i, out_valid[i]);
      end
      @(negedge clk);
      out_ready[i] = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    in_valid[1] = 1'b1; in_data[1] = 48'h0; out_ready[1] = 1'b0;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    n = 0;
    while (out_valid[1] !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL bp_first_latency: got %0d want 4", n);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid[1] = k[0];
      in_data[1]  = {16'($urandom), $urandom};
      #1;
      checks++;
      if (in_ready[1] !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready cycle %0d: got %b want 0", k, in_ready[1]);
      end
      checks++;
      if (out_valid[1] !== 1'b1 || out_data[1] !== 32'hEFA72C4D) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got valid=%b data=%h want 1/efa72c4d",
                 k, out_valid[1], out_data[1]);
      end
    end
    @(negedge clk);
    out_ready[1] = 1'b1; in_valid[1] = 1'b1; in_data[1] = 48'hFFFF_FFFF_FFFF;
    #1;
    checks++;
    if (in_ready[1] !== 1'b1) begin
      errors++; $display("FAIL bp_overlap_ready: got %b want 1", in_ready[1]);
    end
    @(posedge clk); #1;
    in_valid[1] = 1'b0; out_ready[1] = 1'b0; in_data[1] = 48'h0;
    n = 0;
    while (out_valid[1] !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL bp_overlap_latency: got %0d want 4", n);
    end
    checks++;
    if (out_data[1] !== 32'hD9CE3DCB) begin
      errors++; $display("FAIL bp_overlap_data: got %h want d9ce3dcb", out_data[1]);
    end
    @(negedge clk);
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;
  endtask

  task automatic test_exhaustive(input int i);
    int          sent;
    int          cyc;
    logic        acc;
    logic        got;
    logic [31:0] dout;
    logic [31:0] exp;
    logic [47:0] d;
    sb.delete();
    sent = 0;
    cyc  = 0;
    @(negedge clk);
    while ((sent < 512 || sb.size() > 0) && cyc < 512 * 12) begin
      d = (sent < 512) ? (48'(sent % 64) << (42 - 6 * (sent / 64))) : 48'h0;
      drive_cycle(i, sent < 512, d, 1'b1, acc, got, dout);
      if (got) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL exh_extra[%0d]: got %h want none", i, dout);
        end else begin
          exp = sb.pop_front();
          if (dout !== exp) begin
            errors++; $display("FAIL exh_word[%0d]: got %h want %h", i, dout, exp);
          end
        end
      end
      if (acc) begin
        sb.push_back(model(d));
        sent++;
      end
      cyc++;
    end
    in_valid[i] = 1'b0; out_ready[i] = 1'b0;
    checks++;
    if (sent != 512 || sb.size() != 0) begin
      errors++;
      $display("FAIL exh_done[%0d]: got sent=%0d pending=%0d want 512/0", i, sent, sb.size());
    end
  endtask

  task automatic test_reset_mid_busy();
    int seen;
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = 48'hFFFF_FFFF_FFFF; out_ready[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_data[0][31:20] !== 12'hD9C || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_partial: got valid=%b top=%h want 0/d9c", out_valid[0],
               out_data[0][31:20]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0) begin
      errors++; $display("FAIL rst_busy_valid: got %b want 0", out_valid[0]);
    end
    checks++;
    if (out_data[0] !== 32'h0) begin
      errors++; $display("FAIL rst_busy_data: got %h want 0", out_data[0]);
    end
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL rst_busy_ready: got %b want 1", in_ready[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid[0] !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rst_stale_output: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_random_stream(input int i, input int words);
    int          sent;
    int          rcvd;
    int          cyc;
    logic        acc;
    logic        got;
    logic        v;
    logic [31:0] dout;
    logic [31:0] exp;
    logic [47:0] d;
    sb.delete();
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    @(negedge clk);
    while ((sent < words || sb.size() > 0) && cyc < words * 40) begin
      d = {16'($urandom), $urandom};
      v = (sent < words) && ($urandom_range(0, 9) < 6);
      drive_cycle(i, v, d, $urandom_range(0, 9) < 6, acc, got, dout);
      if (got) begin
        rcvd++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_extra[%0d]: got %h want none", i, dout);
        end else begin
          exp = sb.pop_front();
          if (dout !== exp) begin
            errors++; $display("FAIL rand_word[%0d]: got %h want %h", i, dout, exp);
          end
        end
      end
      if (acc) begin
        sb.push_back(model(d));
        sent++;
      end
      cyc++;
    end
    in_valid[i] = 1'b0; out_ready[i] = 1'b0;
    checks++;
    if (rcvd != words || sb.size() != 0) begin
      errors++;
      $display("FAIL rand_count[%0d]: got rcvd=%0d pending=%0d want %0d/0",
               i, rcvd, sb.size(), words);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = 1'b0; in_data[i] = 48'h0; out_ready[i] = 1'b0;
    end
    test_reset();
    test_known_word("zeros", 48'h0, 32'hEFA72C4D);
    test_known_word("ones", 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB);
    test_backpressure();
    test_exhaustive(0);
    test_exhaustive(2);
    test_reset_mid_busy();
    for (int i = 0; i < 4; i++) test_random_stream(i, 250);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
